// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the instruction-fetch port
// and the MEM-stage load/store port. The MEM port wins ties, each access
// holds the RAM for WAIT_CYCLES cycles, and completion is signalled by a
// one-cycle ready pulse with the read data registered beside it.
//
// Handshake: a requester raises its req (if_req, or mem_rd/mem_wr) together
// with address/data and keeps them up until it sees its ready. The request
// is only looked at in IDLE. Once granted, address, data and access type are
// latched, so later changes to the request inputs (including dropping req on
// a flush) do not affect the access in flight. ready pulses for exactly one
// cycle (RESP). A req still high during that cycle is not granted again,
// because RESP always returns to IDLE first.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2   // RAM latency, legal 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    // MEM-stage load/store port
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    // single-port RAM command
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    // pipeline freeze
    output logic        stall_pipe,
    // current arbiter state (IDLE=0, BUSY_IF=1, BUSY_MEM=2, RESP=3)
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Counter load value: BUSY lasts cnt+1 cycles, ending when cnt is 0.
    localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;          // latched access is a store
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic mem_any;
    assign mem_any = mem_rd | mem_wr;

    // State register and all latched/response registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wr_q        <= 1'b0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Next-state logic: grant in IDLE (MEM first), count down in BUSY, respond in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (mem_any) begin
                    // a simultaneous rd+wr is served as a store
                    state_d = BUSY_MEM;
                    cnt_d   = WAIT_M1;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wr_d    = mem_wr;
                end else if (if_req) begin
                    state_d = BUSY_IF;
                    cnt_d   = WAIT_M1;
                    addr_d  = if_addr;
                    wdata_d = 32'd0;
                    wr_d    = 1'b0;
                end
            end
            BUSY_IF: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    if_ready_d = 1'b1;
                    if_rdata_d = ram_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BUSY_MEM: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = wr_q ? 32'd0 : ram_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // never grants here, so a held req cannot be served twice
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM command: enabled through BUSY, write strobe only in the first store cycle.
    always_comb begin
        ram_en = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
        ram_we = (state_q == BUSY_MEM) && wr_q && (cnt_q == WAIT_M1);
    end

    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign if_ready   = if_ready_q;
    assign mem_ready  = mem_ready_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign dbg_state  = state_q;

    // A requester is stalled from the moment it asks until its ready cycle.
    assign stall_pipe = (if_req & ~if_ready_q) | (mem_any & ~mem_ready_q);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: RAM access latency in cycles; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port if_req, input, 1: instruction fetch request, held high until if_ready.
REQ-005 SHALL have port if_addr, input, 32: fetch byte address.
REQ-006 SHALL have port if_rdata, output, 32: fetched instruction, valid while if_ready=1.
REQ-007 SHALL have port if_ready, output, 1: one-cycle fetch completion pulse.
REQ-008 SHALL have ports mem_rd and mem_wr, input, 1 each: MEM-stage load/store request, held high until mem_ready.
REQ-009 SHALL have ports mem_addr and mem_wdata, input, 32 each: MEM-stage address and store data.
REQ-010 SHALL have port mem_rdata, output, 32: load data, valid while mem_ready=1.
REQ-011 SHALL have port mem_ready, output, 1: one-cycle load/store completion pulse.
REQ-012 SHALL have ports ram_en and ram_we, output, 1 each; ram_addr and ram_wdata, output, 32 each: single-port RAM command.
REQ-013 SHALL have port ram_rdata, input, 32: RAM read data, valid WAIT_CYCLES cycles after ram_en first rises.
REQ-014 SHALL have port stall_pipe, output, 1: freezes all pipeline registers, ORed with the hazard-unit stall by the top level.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY_IF, BUSY_MEM, RESP.
REQ-016 In IDLE, a sampled mem_rd|mem_wr SHALL take priority over if_req and move the FSM to BUSY_MEM; otherwise a sampled if_req SHALL move it to BUSY_IF; with no request it SHALL stay in IDLE.
REQ-017 On grant, the winner's address, wdata and type (read/write) SHALL be latched; the latched values, not the live inputs, SHALL drive ram_addr and ram_wdata.
REQ-018 mem_rd and mem_wr both high SHALL be served as a write.
REQ-019 BUSY_x SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded with WAIT_CYCLES-1 at grant.
REQ-020 ram_en SHALL be 1 in every BUSY cycle.
REQ-021 ram_we SHALL be 1 only in the first BUSY_MEM cycle of a write.
REQ-022 When the counter is 0, the next edge SHALL register ram_rdata into the winner's rdata output, move the FSM to RESP, and assert that winner's ready for the RESP cycle only.
REQ-023 Request-to-ready latency SHALL be WAIT_CYCLES+1 cycles, measured from the IDLE sampling edge.
REQ-024 RESP SHALL always return to IDLE and SHALL NOT grant, so a requester still asserting req in its ready cycle is never served twice.
REQ-025 mem_rdata SHALL be 0 after a write.
REQ-026 The rdata output of the non-winner SHALL hold its previous value.
REQ-027 stall_pipe SHALL equal (if_req & ~if_ready) | ((mem_rd|mem_wr) & ~mem_ready), combinationally.
REQ-028 A requester dropping req after grant (e.g. IF flush) SHALL NOT abort the transaction: it completes and its ready still pulses.
REQ-029 Back-to-back access: with both requests pending, MEM SHALL be served first, then IF from the IDLE following RESP.
REQ-030 The block SHALL sustain one access per WAIT_CYCLES+2 cycles.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force IDLE, counter=0, ram_en=0, ram_we=0, if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0 and the latched address/data registers to 0, regardless of the current state.
REQ-032 A write interrupted by reset SHALL NOT issue a further ram_we pulse after rst_n rises.
REQ-033 The first grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-034 Fetch, WAIT_CYCLES=2: if_req=1, if_addr=0x00400000, ram_rdata=0x8C220004 -> ram_en high 2 cycles, if_ready high on cycle 3 with if_rdata=0x8C220004, stall_pipe=1 on cycles 0-2 and 0 on cycle 3.
REQ-035 Simultaneous requests: if_req=1 and mem_rd=1 (addr 0x10010000) in the same cycle -> ram_addr=0x10010000 first, mem_ready on cycle 3, IF granted cycle 4, if_ready cycle 7.
REQ-036 Store: mem_wr=1, addr 0x10010008, wdata 0xDEADBEEF -> ram_we=1 for exactly one cycle with those values, mem_ready on cycle 3, mem_rdata=0.
REQ-037 Flush after grant: if_req dropped one cycle after grant -> transaction completes, if_ready pulses once, no regrant.
REQ-038 Reset mid-BUSY_MEM write, second cycle -> all outputs 0 asynchronously, FSM in IDLE, no ram_we after release.
REQ-039 Held request: if_req held high through ready -> exactly one if_ready pulse per WAIT_CYCLES+2 cycles.
